// File: rtl/key_debouncer_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package key_debouncer_pkg;

    // Per-key debounce state. The encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } key_state_t;

    // 10 ms at 50 MHz.
    localparam int DEFAULT_STABLE_CYCLES = 500000;

    // Smallest counter width that can hold every count value below 'cycles'.
    // Never returns less than 1, so the counter always has at least one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debouncer_channel.sv
// One debounced key: 2-FF synchroniser, stability counter, 4-state FSM and
// registered press/release pulses. All outputs come straight from flops.
module debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = cnt_width(DEFAULT_STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_raw,
    output logic key_n_out,
    output logic press_pulse,
    output logic release_pulse
);

    // The cycle in which UP/DOWN first sees the new level counts as the first
    // stable cycle, so the wait state only needs STABLE_CYCLES-1 more of them.
    // This puts the output change on edge 2+STABLE_CYCLES after the input
    // edge. With STABLE_CYCLES == 1 the wait states are skipped entirely.
    localparam bit             SINGLE     = (STABLE_CYCLES == 1);
    localparam logic [CNT_W-1:0] ACCEPT_CNT =
        CNT_W'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // State register: everything resets to "released, idle".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Synchroniser shift, next-state logic and pulse generation.
    always_comb begin
        sync1_d   = key_n_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            UP: begin
                if (!sync2_q) begin
                    cnt_d = '0;
                    if (SINGLE) begin
                        state_d = DOWN;
                        level_d = 1'b0;
                        press_d = 1'b1;
                    end else begin
                        state_d = WAIT_DOWN;
                    end
                end
            end

            WAIT_DOWN: begin
                if (sync2_q) begin
                    // Bounce back to released: drop the candidate silently.
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == ACCEPT_CNT) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DOWN: begin
                if (sync2_q) begin
                    cnt_d = '0;
                    if (SINGLE) begin
                        state_d   = UP;
                        level_d   = 1'b1;
                        release_d = 1'b1;
                    end else begin
                        state_d = WAIT_UP;
                    end
                end
            end

            WAIT_UP: begin
                if (!sync2_q) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == ACCEPT_CNT) begin
                    state_d   = UP;
                    cnt_d     = '0;
                    level_d   = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_n_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces the raw active-low pushbuttons before they reach the keys PIO.
// Each key gets its own fully independent channel.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_n_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    // One debounce channel per key.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            debounce_channel #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .CNT_W         (CNT_W)
            ) u_channel (
                .clk           (CLOCK_50),
                .rst_n         (reset_n),
                .key_n_raw     (key_n_in[gi]),
                .key_n_out     (key_n_out[gi]),
                .press_pulse   (press_pulse[gi]),
                .release_pulse (release_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with STABLE_CYCLES=8.
// The reference model keeps a window of raw samples per key: a level is
// accepted when the samples taken at edges t-S-1 .. t-2 all agree and differ
// from the current output.
module tb_key_debouncer;

    localparam int NK = 4;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key_n_in = '0;
    logic [NK-1:0] key_n_out;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    always #5 clk = ~clk;

    key_debouncer #(
        .NUM_KEYS      (NK),
        .STABLE_CYCLES (S),
        .CNT_W         (4)
    ) dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .key_n_in      (key_n_in),
        .key_n_out     (key_n_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    logic [NK-1:0] hist [0:S+1];
    logic [NK-1:0] m_out;
    logic [NK-1:0] m_press;
    logic [NK-1:0] m_rel;
    logic [NK-1:0] prev_out;

    function automatic void model_reset();
        for (int i = 0; i <= S + 1; i++) hist[i] = '1;
        m_out   = '1;
        m_press = '0;
        m_rel   = '0;
    endfunction

    function automatic void model_step(input logic [NK-1:0] smp);
        for (int i = 0; i <= S; i++) hist[i] = hist[i+1];
        hist[S+1] = smp;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NK; k++) begin
            int ones;
            ones = 0;
            for (int i = 0; i < S; i++) ones += int'(hist[i][k]);
            if (ones == S && !m_out[k]) begin
                m_out[k] = 1'b1;
                m_rel[k] = 1'b1;
            end else if (ones == 0 && m_out[k]) begin
                m_out[k]   = 1'b0;
                m_press[k] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [NK-1:0] got,
                       input logic [NK-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: drive input, let the edge happen, step model, compare.
    task automatic tick(input logic [NK-1:0] in);
        key_n_in = in;
        @(posedge clk);
        if (reset_n) model_step(in);
        #1;
        chk("model_level", key_n_out, m_out);
        chk("model_press", press_pulse, m_press);
        chk("model_release", release_pulse, m_rel);
        chk("press_and_release", press_pulse & release_pulse, '0);
        chk("fall_needs_press", press_pulse, prev_out & ~key_n_out);
        chk("rise_needs_release", release_pulse, ~prev_out & key_n_out);
        prev_out = key_n_out;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
        prev_out = '1;
        #1;
        chk("async_reset_level", key_n_out, 4'hF);
        chk("async_reset_press", press_pulse, 4'h0);
        chk("async_reset_release", release_pulse, 4'h0);
    endtask

    typedef struct {
        string         name;
        logic [NK-1:0] in;
        int            hold;
        logic [NK-1:0] exp_out;
        logic [NK-1:0] exp_press;
        logic [NK-1:0] exp_rel;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [NK-1:0] rnd_in;

        model_reset();
        prev_out = '1;

        // 1: reset with all keys held down, then full latency after release.
        reset_n  = 1'b0;
        key_n_in = 4'h0;
        tick(4'h0);
        tick(4'h0);
        chk("reset_level", key_n_out, 4'hF);
        chk("reset_press", press_pulse, 4'h0);
        chk("reset_release", release_pulse, 4'h0);
        reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) tick(4'h0);
        chk("t1_edge9_level", key_n_out, 4'hF);
        tick(4'h0);
        chk("t1_edge10_level", key_n_out, 4'h0);
        chk("t1_edge10_press", press_pulse, 4'hF);
        tick(4'h0);
        chk("t1_edge11_press", press_pulse, 4'h0);
        $display("reset test: level=%h after power-on press", key_n_out);
        for (int i = 0; i < 12; i++) tick(4'hF);
        chk("t1_all_released", key_n_out, 4'hF);

        // 2/3/4: table-driven sequences.
        vecs.push_back('{"idle",            4'hF, 4, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"press0_edge9",    4'hE, 9, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"press0_edge10",   4'hE, 1, 4'hE, 4'h1, 4'h0});
        vecs.push_back('{"press0_pulse_end",4'hE, 1, 4'hE, 4'h0, 4'h0});
        vecs.push_back('{"press0_held",     4'hE, 5, 4'hE, 4'h0, 4'h0});
        vecs.push_back('{"rel0_edge9",      4'hF, 9, 4'hE, 4'h0, 4'h0});
        vecs.push_back('{"rel0_edge10",     4'hF, 1, 4'hF, 4'h0, 4'h1});
        vecs.push_back('{"rel0_pulse_end",  4'hF, 1, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"bounce_low5",     4'hD, 5, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"bounce_high2",    4'hF, 2, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"bounce_low5b",    4'hD, 5, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"bounce_high",     4'hF, 3, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"stable1_edge9",   4'hD, 9, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"stable1_edge10",  4'hD, 1, 4'hD, 4'h2, 4'h0});
        vecs.push_back('{"stable1_held",    4'hD, 3, 4'hD, 4'h0, 4'h0});
        vecs.push_back('{"rel1_edge10",     4'hF, 10,4'hF, 4'h0, 4'h2});
        vecs.push_back('{"rel1_pulse_end",  4'hF, 1, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"multi_edge9",     4'h6, 9, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{"multi_edge10",    4'h6, 1, 4'h6, 4'h9, 4'h0});
        vecs.push_back('{"multi_pulse_end", 4'h6, 1, 4'h6, 4'h0, 4'h0});
        vecs.push_back('{"multi_rel_edge9", 4'hF, 9, 4'h6, 4'h0, 4'h0});
        vecs.push_back('{"multi_rel_edge10",4'hF, 1, 4'hF, 4'h0, 4'h9});
        vecs.push_back('{"multi_rel_end",   4'hF, 1, 4'hF, 4'h0, 4'h0});

        foreach (vecs[v]) begin
            for (int c = 0; c < vecs[v].hold; c++) tick(vecs[v].in);
            chk({vecs[v].name, "_level"},   key_n_out,     vecs[v].exp_out);
            chk({vecs[v].name, "_press"},   press_pulse,   vecs[v].exp_press);
            chk({vecs[v].name, "_release"}, release_pulse, vecs[v].exp_rel);
            $display("vector %-18s in=%h hold=%0d -> level=%h press=%h release=%h",
                     vecs[v].name, vecs[v].in, vecs[v].hold,
                     key_n_out, press_pulse, release_pulse);
        end

        // 5: reset while key 2 is mid-count, then full latency again.
        for (int i = 0; i < 7; i++) tick(4'hB);
        chk("t5_before_reset", key_n_out, 4'hF);
        assert_reset();
        for (int i = 0; i < 3; i++) tick(4'hB);
        chk("t5_in_reset", key_n_out, 4'hF);
        reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) tick(4'hB);
        chk("t5_edge9_level", key_n_out, 4'hF);
        chk("t5_edge9_press", press_pulse, 4'h0);
        tick(4'hB);
        chk("t5_edge10_level", key_n_out, 4'hB);
        chk("t5_edge10_press", press_pulse, 4'h4);
        $display("reset-mid-count test: level=%h press=%h", key_n_out, press_pulse);
        for (int i = 0; i < 12; i++) tick(4'hF);

        // Randomised run against the window model, with occasional resets.
        rnd_in = 4'hF;
        for (int b = 0; b < 30; b++) begin
            for (int c = 0; c < 100; c++) begin
                for (int k = 0; k < NK; k++)
                    if ($urandom_range(0, 9) == 0) rnd_in[k] = ~rnd_in[k];
                if ($urandom_range(0, 399) == 0) begin
                    assert_reset();
                    tick(rnd_in);
                    reset_n = 1'b1;
                end
                tick(rnd_in);
            end
            $display("random burst %0d: in=%h level=%h", b, rnd_in, key_n_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
